// File: rtl/divider_seq.sv
// Iterative radix-2 restoring divider, o = {remainder, quotient}, WIDTH+2 cycle latency.
// Define DIV_EARLY_OUT_EN to finish in two cycles when b==0 or |b| > |a|.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               symbol,
    output logic [2*WIDTH-1:0] o,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [1:0]         dbg_state
);

    // Handshake: start is taken only in IDLE; busy is high in CALC and FIX;
    // done pulses for exactly one cycle with o/div_zero valid, and they hold until the next start.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] o_q, o_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    assign mag_a   = (symbol && a[WIDTH-1]) ? -a : a;
    assign mag_b   = (symbol && b[WIDTH-1]) ? -b : b;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign fix_quo = neg_quo_q ? -quo_q : quo_q;
    assign fix_rem = neg_rem_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            o_q       <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            a_q       <= a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            o_q       <= o_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        a_d       = a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        o_d       = o_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    dvs_d     = mag_b;
                    rem_d     = '0;
                    quo_d     = mag_a;
                    neg_quo_d = symbol & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = symbol & a[WIDTH-1];
                    zero_d    = (b == '0);
                    cnt_d     = '0;
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    // Quotient is zero: park |a| as the remainder and skip straight to sign fix-up.
                    if (b == '0 || mag_b > mag_a) begin
                        rem_d   = mag_a;
                        quo_d   = '0;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                o_d     = zero_q ? {a_q, {WIDTH{1'b1}}} : {fix_rem, fix_quo};
                dz_d    = zero_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o         = o_q;
    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vector table, handshake corner cases, random division.
// Honours DIV_EARLY_OUT_EN when predicting latency.
module tb_divider_seq;

    localparam int W      = 32;
    localparam int BUDGET = 60;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           symbol;
    logic [2*W-1:0] o;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic [1:0]     dbg_state;

    divider_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .symbol    (symbol),
        .o         (o),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard entries are {div_zero, remainder, quotient}
    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_exp = '0;

    typedef struct {
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic         ts;
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        logic         dz;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic logic [2*W:0] model_div(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        logic [W-1:0] q, r;
        longint sa, sb;
        if (tb == '0) return {1'b1, ta, {W{1'b1}}};
        if (ts) begin
            sa = longint'($signed(ta));
            sb = longint'($signed(tb));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = ta / tb;
            r = ta % tb;
        end
        return {1'b0, r, q};
    endfunction

    function automatic int model_lat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        longint ma, mb;
        ma = ts ? longint'($signed(ta)) : longint'({1'b0, ta});
        mb = ts ? longint'($signed(tb)) : longint'({1'b0, tb});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (EARLY_EN && (tb == '0 || mb > ma)) return 2;
        return W + 2;
    endfunction

    // Driver: cycle 0 is the cycle start is presented; poke re-raises start with junk operands in cycle poke.
    task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input int poke);
        logic [2*W:0]   exp;
        logic [2*W-1:0] got_o;
        logic           got_dz;
        int             exp_lat;
        int             lat;
        bit             busy_ok;
        exp_lat = model_lat(ta, tb, ts);
        busy_ok = 1'b1;
        lat     = -1;
        got_o   = '0;
        got_dz  = 1'b0;
        a       = ta;
        b       = tb;
        symbol  = ts;
        start   = 1'b1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == poke) begin
                a      = $urandom;
                b      = $urandom;
                symbol = ~ts;
                start  = 1'b1;
            end
            if (done) begin
                lat    = c;
                got_o  = o;
                got_dz = div_zero;
                break;
            end
            if (busy !== (c < exp_lat)) busy_ok = 1'b0;
            if (c == poke) check("o held while busy", o, last_exp[2*W-1:0]);
        end
        exp = exp_q.pop_front();
        check("done latency", 64'(lat), 64'(exp_lat));
        check("result o", got_o, exp[2*W-1:0]);
        check("div_zero", 64'(got_dz), 64'(exp[2*W]));
        check("busy window", 64'(busy_ok), 64'd1);
        last_exp = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("single done pulse", 64'(done), 64'd0);
        check("idle after done", 64'(busy), 64'd0);
    endtask

    initial begin
        bit           saw_done;
        logic [W-1:0] ra, rb;
        logic         rs;

        tbl[0]  = '{32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        1'b0};
        tbl[1]  = '{32'hFA4B_7D9F, 32'h1111_1111, 1'b0, 32'h0B5C_8EB1, 32'h0000_000E, 1'b0};
        tbl[2]  = '{32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
        tbl[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[4]  = '{32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{32'h1234_5678, 32'h0,         1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        tbl[6]  = '{32'd100,       32'hFFFF_FFF9, 1'b1, 32'd2,         32'hFFFF_FFF2, 1'b0};
        tbl[7]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 32'd14,        1'b0};
        tbl[8]  = '{32'd7,         32'd100,       1'b0, 32'd7,         32'd0,         1'b0};
        tbl[9]  = '{32'd7,         32'hFFFF_FF9C, 1'b1, 32'd7,         32'd0,         1'b0};
        tbl[10] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF, 1'b0};
        tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'd0,         1'b0};

        // Reset
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        symbol = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset o", o, '0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({tbl[i].dz, tbl[i].rem, tbl[i].quo});
            run_div(tbl[i].ta, tbl[i].tb, tbl[i].ts, 0);
        end

        // Start pulse during busy (cycle 5) is ignored and o stays at the previous result
        exp_q.push_back({1'b0, 32'd2, 32'd14});
        run_div(32'd100, 32'd7, 1'b0, 5);

        // Start pulse in the DONE cycle is ignored
        exp_q.push_back(model_div(32'hFA4B_7D9F, 32'h1111_1111, 1'b0));
        run_div(32'hFA4B_7D9F, 32'h1111_1111, 1'b0, model_lat(32'hFA4B_7D9F, 32'h1111_1111, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("o persists in idle", o, last_exp[2*W-1:0]);

        // Reset at cycle 10 of a division aborts it
        a      = 32'hDEAD_BEEF;
        b      = 32'd3;
        symbol = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy before abort", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort o", o, '0);
        check("abort done", 64'(done), 64'd0);
        check("abort div_zero", 64'(div_zero), 64'd0);
        saw_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no completion after abort", 64'(saw_done), 64'd0);
        last_exp = '0;
        exp_q.push_back({1'b0, 32'd2, 32'd14});
        run_div(32'd100, 32'd7, 1'b0, 0);

        // Random division against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 255));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            exp_q.push_back(model_div(ra, rb, rs));
            run_div(ra, rb, rs, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Iterative radix-2 restoring divider; the sequential counterpart to the combinational multiplier in the Citrus CPU datapath.
- Serves DIV/DIVU: takes a dividend a, a divisor b and a signed flag symbol.
- Returns {remainder, quotient} on o, matching the multiplier's {HI, LO} packing.
- Multi-cycle with a start/busy/done handshake; the EX stage stalls while busy=1.

Parameters:
- WIDTH, 32, operand width; o is 2*WIDTH wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- a  input  WIDTH  dividend; latched on accepted start
- b  input  WIDTH  divisor; latched on accepted start
- symbol  input  1  1 = signed (two's complement), 0 = unsigned; latched on start
- o  output  2*WIDTH  {remainder, quotient}; held until the next accepted start
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse; o valid in this cycle
- div_zero  output  1  latched with o; 1 if the latched b was 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: state=IDLE, o=0, busy=0, done=0, div_zero=0, internal counter and registers cleared.
- Reset mid-operation aborts immediately; no done pulse is produced.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and special cases.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - IDLE->CALC on start=1.
  - CALC->FIX when the iteration counter reaches WIDTH-1.
  - FIX->DONE.
  - DONE->IDLE.
- Latency: start sampled in cycle 0; CALC in cycles 1..WIDTH; FIX in cycle WIDTH+1; done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- busy=1 in CALC and FIX; 0 in IDLE and DONE.
- start while busy=1 or in DONE is ignored; no queueing.
- Operand capture at start:
  - Signed mode: magnitudes |a| and |b| are stored, plus sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Unsigned mode: raw values are stored; both sign flags are 0.
- CALC iteration: shift {rem, quo} left by 1, bringing in the next dividend bit. Trial subtract rem-|b| at WIDTH+1 bits. If non-negative, keep the difference and set quo LSB=1; otherwise restore and set LSB=0.
- FIX:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem : rem.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Divide by zero (b==0): quotient=all ones, remainder=original a (unmodified), div_zero=1. Signed and unsigned behave the same. Latency is unchanged.
- Signed overflow (most-negative / -1): quotient=most-negative, remainder=0. This falls out of the magnitude path; no special case is needed.
- o, div_zero update only in FIX->DONE and persist afterwards; done is never high for two consecutive cycles.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in cycle 0, if b==0 or magnitude(b) > magnitude(a) (unsigned compare of the stored magnitudes), go IDLE->FIX directly.
  - Result: quotient=0, remainder=a (or the divide-by-zero result).
  - done in cycle 2; busy=1 only in cycle 1.
  - All other divisions keep full latency.
- Undefined: every division takes WIDTH+2 cycles; the comparator logic is absent.

Test Plan:
- Unsigned, a=32'd100, b=32'd7 -> o={32'd2, 32'd14}, div_zero=0, done exactly in cycle 34, busy high in cycles 1..33.
- Unsigned, a=32'hFA4B_7D9F, b=32'h1111_1111 -> o={32'h0B5C_8EB1, 32'h0000_000E}.
- Signed, a=32'hFFFF_FF9C (-100), b=32'd7 -> quotient=32'hFFFF_FFF2 (-14), remainder=32'hFFFF_FFFE (-2).
- Signed, a=32'h8000_0000, b=32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0.
- Divide by zero, a=32'h1234_5678, b=0, symbol=1 -> quotient=32'hFFFF_FFFF, remainder=32'h1234_5678, div_zero=1.
  - With DIV_EARLY_OUT_EN: done in cycle 2.
  - Without it: done in cycle 34.
- Start pulse at cycle 5 during busy -> ignored; o unchanged.
- Assert rst at cycle 10 of a new division -> busy=0, o=0, no done; fresh start afterwards completes normally.
